// File: rtl/mobo_bus_arbiter_if.sv
// mobo_bus_arbiter_if: requester handshakes and motherboard bus signals shared by the arbiter.
interface mobo_bus_arbiter_if #(parameter int WORD_WIDTH = 32);
  logic req0_valid, req0_we, req0_ack, req0_err;
  logic req1_valid, req1_we, req1_ack, req1_err;
  logic [WORD_WIDTH-1:0] req0_addr, req0_wdata, req0_rdata;
  logic [WORD_WIDTH-1:0] req1_addr, req1_wdata, req1_rdata;
  logic [WORD_WIDTH-1:0] mobo_ctrl, mobo_stat, mobo_addr, mobo_dat_out, mobo_dat_in;
  logic busy, owner;
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  mobo_stat, mobo_dat_in,
    output req0_ack, req0_rdata, req0_err, req1_ack, req1_rdata, req1_err,
    output mobo_ctrl, mobo_addr, mobo_dat_out, busy, owner
  );
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output mobo_stat, mobo_dat_in,
    input  req0_ack, req0_rdata, req0_err, req1_ack, req1_rdata, req1_err,
    input  mobo_ctrl, mobo_addr, mobo_dat_out, busy, owner
  );
endinterface

// File: rtl/mobo_bus_arbiter.sv
// mobo_bus_arbiter: round-robin two-port arbiter running one timed-out motherboard transaction per grant.
module mobo_bus_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  mobo_bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [WORD_WIDTH-1:0] CMD_READ = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] CMD_WRITE = WORD_WIDTH'(2);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] ctrl_q, ctrl_d, addr_q, addr_d, dout_q, dout_d;
  logic [WORD_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d, rd;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] ack_q, ack_d, err_q, err_d;
  logic owner_q, owner_d, last_q, last_d, busy_q, busy_d;
  logic sel, we, done, expired, fail;
  logic unused_stat;
  // On a tie the port that did not win last time gets the bus.
  assign sel = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
  assign we = sel ? bus.req1_we : bus.req0_we;
  assign done = bus.mobo_stat[0];
  assign expired = cnt_q == CW'(TIMEOUT - 1);
  assign fail = done ? bus.mobo_stat[1] : 1'b1;
  assign rd = (done && !ctrl_q[1]) ? bus.mobo_dat_in : '0;
  assign unused_stat = ^bus.mobo_stat[WORD_WIDTH-1:2];
  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    addr_d = addr_q;
    dout_d = dout_q;
    cnt_d = cnt_q;
    owner_d = owner_q;
    last_d = last_q;
    busy_d = busy_q;
    ack_d = '0;
    err_d = '0;
    rd0_d = '0;
    rd1_d = '0;
    case (state_q)
      IDLE: if (bus.req0_valid || bus.req1_valid) begin
        state_d = BUS;
        owner_d = sel;
        last_d = sel;
        busy_d = 1'b1;
        cnt_d = '0;
        ctrl_d = we ? CMD_WRITE : CMD_READ;
        addr_d = sel ? bus.req1_addr : bus.req0_addr;
        dout_d = we ? (sel ? bus.req1_wdata : bus.req0_wdata) : '0;
      end
      BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (done || expired) begin
          state_d = RESP;
          ctrl_d = '0;
          ack_d = owner_q ? 2'b10 : 2'b01;
          err_d = {owner_q & fail, ~owner_q & fail};
          rd0_d = owner_q ? '0 : rd;
          rd1_d = owner_q ? rd : '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      addr_q <= '0;
      dout_q <= '0;
      cnt_q <= '0;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      busy_q <= 1'b0;
      ack_q <= '0;
      err_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      cnt_q <= cnt_d;
      owner_q <= owner_d;
      last_q <= last_d;
      busy_q <= busy_d;
      ack_q <= ack_d;
      err_q <= err_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
    end
  end
  assign bus.mobo_ctrl = ctrl_q;
  assign bus.mobo_addr = addr_q;
  assign bus.mobo_dat_out = dout_q;
  assign bus.busy = busy_q;
  assign bus.owner = owner_q;
  assign bus.req0_ack = ack_q[0];
  assign bus.req1_ack = ack_q[1];
  assign bus.req0_err = err_q[0];
  assign bus.req1_err = err_q[1];
  assign bus.req0_rdata = rd0_q;
  assign bus.req1_rdata = rd1_q;
endmodule
